alu_resp_fifo: RTL and testbench
================================

ALU_RESP_FIFO -- requirements
Module: alu_resp_fifo

Interface
REQ-001: Parameter DEPTH, default 4, result-buffer entries; SHALL be a power of two and at least 4.
REQ-002: Parameter WIDTH, default 32, result data width.
REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005: alu_issue  input  1  upstream is driving valid_i=1 into the ALU this cycle.
REQ-006: alu_valid  input  1  ALU valid_o: the result on alu_f is valid this cycle.
REQ-007: alu_f  input  WIDTH  ALU result f.
REQ-008: issue_ok  output  1  credit: upstream may assert alu_issue this cycle.
REQ-009: res_valid  output  1  the head entry is available to the consumer.
REQ-010: res_ready  input  1  the consumer accepts the head entry.
REQ-011: res_data  output  WIDTH  head entry data.
REQ-012: count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013: overflow  output  1  sticky flag: a result was dropped.

Function
REQ-014: The ALU has a fixed 2-cycle latency: alu_issue at cycle N SHALL correspond to alu_valid at cycle N+2; this block SHALL NOT assume any other latency.
REQ-015: inflight counter (width $clog2(DEPTH)+1): +1 on alu_issue only; -1 on alu_valid only; unchanged when both or neither are asserted.
REQ-016: inflight SHALL saturate at 0; alu_valid with inflight=0 SHALL NOT underflow it.
REQ-017: issue_ok SHALL be combinational: (count + inflight) < DEPTH, using registered values only; a same-cycle pop SHALL NOT be credited.
REQ-018: Push: alu_valid=1 and (count<DEPTH or pop in the same cycle) SHALL write alu_f at wr_ptr and advance wr_ptr.
REQ-019: Pop: res_valid=1 and res_ready=1 SHALL advance rd_ptr.
REQ-020: Pointers are $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-021: count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022: res_valid SHALL equal (count != 0), registered; no fall-through: a push in cycle N SHALL become visible in cycle N+1 at the earliest.
REQ-023: res_data SHALL be mem[rd_ptr] when res_valid=1 and SHALL be 0 when the buffer is empty.
REQ-024: Drop: alu_valid=1 with count=DEPTH and no pop SHALL discard alu_f, leave the buffer unchanged, and set overflow=1.
REQ-025: overflow SHALL stay 1 until reset.
REQ-026: alu_issue while issue_ok=0 is a protocol violation; the block SHALL still count it in inflight, and any resulting drop is handled per REQ-024.
REQ-027: Data order SHALL be strict FIFO; no entry is duplicated or reordered.

Reset
REQ-028: rst_n=0 SHALL asynchronously clear wr_ptr, rd_ptr, count, inflight and overflow; res_valid=0, res_data=0, issue_ok=1.
REQ-029: Buffer memory contents need no reset.
REQ-030: Reset during operation SHALL discard all stored entries and all inflight credit.
REQ-031: An alu_valid arriving after rst_n deasserts SHALL be pushed normally, with inflight held at 0 per REQ-016.

Verification (DEPTH=4)
REQ-032: rst_n low for 2 cycles -> res_valid=0, count=0, issue_ok=1, overflow=0, res_data=0.
REQ-033: alu_issue at c0; alu_valid with alu_f=0x00000007 at c2; res_ready=1 -> res_valid=1 and res_data=7 at c3; count=0 and res_valid=0 at c4.
REQ-034: res_ready=0; alu_issue at c0..c3 -> issue_ok=0 from c4; results 0x1,0x2,0x3,0x4 arrive c2..c5 -> count=4, overflow=0, popped in order 1,2,3,4.
REQ-035: Buffer full; alu_valid with alu_f=0xAA and res_ready=1 in the same cycle -> head popped, 0xAA stored at the tail, count stays 4, overflow=0.
REQ-036: Buffer full; res_ready=0; alu_valid with alu_f=0xBB -> 0xBB dropped, overflow=1 and stays 1, count=4, contents unchanged.
REQ-037: Two issues in flight, rst_n pulsed low at c1 -> all cleared; late alu_valid with 0x55 at c2 after deassert -> count=1, inflight=0, res_data=0x55 at c3.

Source files
------------

// File: rtl/alu_resp_if.sv
// alu_resp_if -- handshake bundle between the ALU/upstream side and the
// alu_resp_fifo result buffer.
//   alu_issue  : upstream drives valid into the ALU this cycle
//   alu_valid  : ALU result on alu_f is valid this cycle
//   alu_f      : ALU result data
//   issue_ok   : credit, upstream may issue this cycle
//   res_valid  : head entry available to the consumer
//   res_ready  : consumer accepts the head entry
//   res_data   : head entry data (0 when empty)
//   count      : number of stored entries
//   overflow   : sticky, a result was dropped
// The buffer side uses modport slave; the driver of ALU/consumer signals uses master.
interface alu_resp_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             alu_issue;
  logic             alu_valid;
  logic [WIDTH-1:0] alu_f;
  logic             issue_ok;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [CW-1:0]    count;
  logic             overflow;

  modport master (
    output alu_issue, alu_valid, alu_f, res_ready,
    input  issue_ok, res_valid, res_data, count, overflow
  );

  modport slave (
    input  alu_issue, alu_valid, alu_f, res_ready,
    output issue_ok, res_valid, res_data, count, overflow
  );
endinterface

// File: rtl/alu_resp_fifo.sv
// alu_resp_fifo -- credit-managed result buffer behind a fixed 2-cycle ALU.
// Tracks results still inside the ALU (inflight) so that upstream only gets
// issue credit when a buffer slot is guaranteed for the result. Results are
// stored in strict FIFO order; a result arriving at a full buffer without a
// simultaneous pop is dropped and flagged by a sticky overflow bit.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_resp_if.slave (ALU result input, issue credit, consumer side)
module alu_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_resp_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_C    = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [AW-1:0] ONE_P     = AW'(1);
  localparam logic [CW:0]   OCC_LIMIT = (CW+1)'(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("alu_resp_fifo: DEPTH must be a power of two and at least 4");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          res_valid_q, res_valid_d;
  logic          overflow_q, overflow_d;

  logic          push, pop, drop;
  logic [CW:0]   occupancy;

  assign pop  = res_valid_q & bus.res_ready;
  // A full buffer can still accept when the head leaves in the same cycle.
  assign push = bus.alu_valid & ((count_q != FULL_C) | pop);
  assign drop = bus.alu_valid & ~push;

  // Credit uses registered state only; a same-cycle pop is not counted.
  assign occupancy    = {1'b0, count_q} + {1'b0, inflight_q};
  assign bus.issue_ok = (occupancy < OCC_LIMIT);

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_valid_q ? mem_q[rd_ptr_q] : '0;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    inflight_d  = inflight_q;
    overflow_d  = overflow_q | drop;

    if (push) wr_ptr_d = wr_ptr_q + ONE_P;
    if (pop)  rd_ptr_d = rd_ptr_q + ONE_P;

    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // Saturate at zero: a result whose issue was wiped by reset must not
    // wrap the counter.
    if (bus.alu_issue && !bus.alu_valid) begin
      inflight_d = inflight_q + ONE_C;
    end else if (bus.alu_valid && !bus.alu_issue && (inflight_q != '0)) begin
      inflight_d = inflight_q - ONE_C;
    end

    // Registered view of non-empty; no fall-through of a fresh push.
    res_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= '0;
      res_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      res_valid_q <= res_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage carries no reset; validity is governed by count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.alu_f;
  end
endmodule

// File: tb/tb_alu_resp_fifo.sv
module tb_alu_resp_fifo;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_resp_if #(.DEPTH(4), .WIDTH(32)) bus ();

  alu_resp_fifo #(.DEPTH(4), .WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] drain_exp [4];

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.alu_issue = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_f     = '0;
    bus.res_ready = 1'b0;

    // Reset held for two cycles
    tick();
    tick();
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_count",     64'(bus.count),     64'd0);
    chk("rst_issue_ok",  64'(bus.issue_ok),  64'd1);
    chk("rst_overflow",  64'(bus.overflow),  64'd0);
    chk("rst_res_data",  64'(bus.res_data),  64'd0);
    rst_n = 1'b1;

    // Single transaction: issue c0, result 7 at c2, visible c3, popped by c4
    bus.alu_issue = 1'b1;
    tick();
    bus.alu_issue = 1'b0;
    chk("single_inflight_c1", 64'(dut.inflight_q), 64'd1);
    chk("single_valid_c1",    64'(bus.res_valid),  64'd0);
    tick();
    bus.alu_valid = 1'b1;
    bus.alu_f     = 32'h7;
    bus.res_ready = 1'b1;
    tick();
    bus.alu_valid = 1'b0;
    chk("single_valid_c3", 64'(bus.res_valid),  64'd1);
    chk("single_data_c3",  64'(bus.res_data),   64'd7);
    chk("single_count_c3", 64'(bus.count),      64'd1);
    chk("single_infl_c3",  64'(dut.inflight_q), 64'd0);
    tick();
    chk("single_count_c4", 64'(bus.count),     64'd0);
    chk("single_valid_c4", 64'(bus.res_valid), 64'd0);
    chk("single_data_c4",  64'(bus.res_data),  64'd0);
    bus.res_ready = 1'b0;

    // Fill: issues c0..c3, results 1..4 at c2..c5, credit closes at c4
    for (int c = 0; c < 6; c++) begin
      bus.alu_issue = (c < 4);
      bus.alu_valid = (c >= 2);
      bus.alu_f     = (c >= 2) ? 32'(c - 1) : 32'h0;
      if (c == 3) chk("fill_issue_ok_c3", 64'(bus.issue_ok), 64'd1);
      if (c >= 4) chk("fill_issue_ok_c4plus", 64'(bus.issue_ok), 64'd0);
      tick();
    end
    bus.alu_issue = 1'b0;
    bus.alu_valid = 1'b0;
    chk("fill_count",    64'(bus.count),      64'd4);
    chk("fill_overflow", 64'(bus.overflow),   64'd0);
    chk("fill_issue_ok", 64'(bus.issue_ok),   64'd0);
    chk("fill_inflight", 64'(dut.inflight_q), 64'd0);
    chk("fill_head",     64'(bus.res_data),   64'd1);

    // Full buffer, push 0xAA with simultaneous pop of head 1
    bus.alu_valid = 1'b1;
    bus.alu_f     = 32'hAA;
    bus.res_ready = 1'b1;
    tick();
    bus.alu_valid = 1'b0;
    bus.res_ready = 1'b0;
    chk("pushpop_count",    64'(bus.count),    64'd4);
    chk("pushpop_overflow", 64'(bus.overflow), 64'd0);
    chk("pushpop_head",     64'(bus.res_data), 64'd2);

    // Full buffer, no pop: 0xBB dropped
    bus.alu_valid = 1'b1;
    bus.alu_f     = 32'hBB;
    tick();
    bus.alu_valid = 1'b0;
    chk("drop_overflow", 64'(bus.overflow), 64'd1);
    chk("drop_count",    64'(bus.count),    64'd4);
    chk("drop_head",     64'(bus.res_data), 64'd2);

    // Drain in FIFO order
    drain_exp[0] = 32'h2;
    drain_exp[1] = 32'h3;
    drain_exp[2] = 32'h4;
    drain_exp[3] = 32'hAA;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_%0d", i), 64'(bus.res_data), 64'(drain_exp[i]));
      tick();
    end
    bus.res_ready = 1'b0;
    chk("drain_count",    64'(bus.count),     64'd0);
    chk("drain_valid",    64'(bus.res_valid), 64'd0);
    chk("drain_overflow", 64'(bus.overflow),  64'd1);
    chk("drain_issue_ok", 64'(bus.issue_ok),  64'd1);

    // Reset during operation: one stored entry plus two issues in flight
    bus.alu_valid = 1'b1;
    bus.alu_f     = 32'h99;
    tick();
    bus.alu_valid = 1'b0;
    bus.alu_issue = 1'b1;
    tick();
    tick();
    bus.alu_issue = 1'b0;
    chk("mid_count",    64'(bus.count),      64'd1);
    chk("mid_inflight", 64'(dut.inflight_q), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count",    64'(bus.count),      64'd0);
    chk("arst_inflight", 64'(dut.inflight_q), 64'd0);
    chk("arst_valid",    64'(bus.res_valid),  64'd0);
    chk("arst_overflow", 64'(bus.overflow),   64'd0);
    chk("arst_issue_ok", 64'(bus.issue_ok),   64'd1);
    chk("arst_data",     64'(bus.res_data),   64'd0);
    #1 rst_n = 1'b1;
    tick();
    bus.alu_valid = 1'b1;
    bus.alu_f     = 32'h55;
    tick();
    bus.alu_valid = 1'b0;
    chk("late_count",    64'(bus.count),      64'd1);
    chk("late_inflight", 64'(dut.inflight_q), 64'd0);
    chk("late_valid",    64'(bus.res_valid),  64'd1);
    chk("late_data",     64'(bus.res_data),   64'h55);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
